// File: rtl/avalon_st_to_frame_writer.sv
// -----------------------------------------------------------------------------
// avalon_st_to_frame_writer
//
// Avalon-ST video sink. Takes 30-bit RGB pixels (10 bits per channel), keeps
// the top 4 bits of each channel (RGB444) and writes them sequentially into a
// frame buffer write port. Packet framing (SOP/EOP against WIDTH*HEIGHT) is
// checked; good frames pulse frame_done and bump frame_count, bad framing
// pulses frame_error.
//
// Ports:
//   clk, rst            system clock (rising edge), async active-low reset
//   data_in_avalon      pixel {R[9:0],G[9:0],B[9:0]}
//   startofpacket_in    SOP, first pixel of frame
//   endofpacket_in      EOP, last pixel of frame
//   valid_in            beat valid
//   ready_out           sink ready (0 while in reset)
//   wr_addr/wr_data     frame buffer write address / packed pixel
//   wr_en               write request, held until wr_ready
//   wr_ready            frame buffer accepts the write this cycle
//   frame_done          one-cycle pulse, frame of correct length received
//   frame_error         one-cycle pulse, framing error
//   frame_count         good frame count, wraps
//
// States:
//   S_IDLE     | waiting for SOP; non-SOP beats are dropped silently
//   S_RECV     | receiving a frame, pixel counter = next write index
//   S_OVERFLOW | frame ran past WIDTH*HEIGHT; drop beats until EOP or SOP
// -----------------------------------------------------------------------------
module avalon_st_to_frame_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       data_in_avalon,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              frame_error,
  output logic [15:0]       frame_count
);

  localparam int FRAME_PIX = WIDTH * HEIGHT;
  // One extra bit so the counter can represent FRAME_PIX itself even when
  // FRAME_PIX == 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] LAST_PIX_C  = CNT_W'(FRAME_PIX - 1);
  localparam bit SINGLE_PIX = (FRAME_PIX == 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECV     = 2'd1,
    S_OVERFLOW = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         fcount_q, fcount_d;

  logic                accept;
  logic                sop;
  logic                eop;
  logic [11:0]         packed_px;
  logic [CNT_W-1:0]    cnt_inc;
  logic                do_write;
  logic [CNT_W-1:0]    write_idx;
  logic                abort;

  // Only the top nibble of each channel is stored.
  logic unused_data_bits;
  assign unused_data_bits = ^{data_in_avalon[25:20], data_in_avalon[15:10],
                              data_in_avalon[5:0]};

  // Single output register, no skid: the input may only advance when the
  // write register is empty or being drained this cycle.
  assign ready_out = rst && (!wr_en_q || wr_ready);
  assign accept    = valid_in && ready_out;
  assign sop       = startofpacket_in;
  assign eop       = endofpacket_in;
  assign packed_px = {data_in_avalon[29:26], data_in_avalon[19:16],
                      data_in_avalon[9:6]};
  assign cnt_inc   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fcount_q  <= fcount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = wr_en_q && !wr_ready;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fcount_d  = fcount_q;
    do_write  = 1'b0;
    write_idx = '0;
    abort     = 1'b0;

    if (accept) begin
      if (sop) begin
        // SOP always starts a fresh frame at pixel 0; outside IDLE it also
        // abandons whatever frame was in flight.
        abort     = (state_q != S_IDLE);
        do_write  = 1'b1;
        write_idx = '0;
        if (eop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (SINGLE_PIX && !abort) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d   = abort;
          cnt_d   = CNT_W'(1);
          state_d = SINGLE_PIX ? S_OVERFLOW : S_RECV;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            // stray beat outside a packet: accepted and dropped
          end
          S_RECV: begin
            do_write  = 1'b1;
            write_idx = cnt_q;
            if (eop) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              if (cnt_q == LAST_PIX_C) begin
                done_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == FRAME_PIX_C) begin
                state_d = S_OVERFLOW;
              end
            end
          end
          S_OVERFLOW: begin
            if (eop) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = write_idx[ADDR_W-1:0];
      wr_data_d = packed_px;
    end

    if (done_d) begin
      fcount_d = fcount_q + 16'd1;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_avalon_st_to_frame_writer.sv
module tb_avalon_st_to_frame_writer;

  logic        clk;
  logic        rst;
  logic [29:0] data_in_avalon;
  logic        startofpacket_in;
  logic        endofpacket_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;
  logic        wr_ready;
  logic        frame_done;
  logic        frame_error;
  logic [15:0] frame_count;

  avalon_st_to_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_avalon   (data_in_avalon),
    .startofpacket_in (startofpacket_in),
    .endofpacket_in   (endofpacket_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .wr_ready         (wr_ready),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .frame_count      (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic        e;
    logic [29:0] d;
    logic        wrr;
    logic        rdy;
    logic        wen;
    logic [2:0]  addr;
    logic [11:0] wd;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs_main[$];
  vec_t vecs_post[$];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cur    = 0;

  // Low bits of each channel are deliberately non-zero so a wrong slice in
  // the packer shows up in wr_data.
  function automatic logic [29:0] px(input logic [3:0] r, input logic [3:0] g,
                                     input logic [3:0] b);
    return {r, 6'b101101, g, 6'b010011, b, 6'b110001};
  endfunction

  function automatic vec_t mk(input int v, input int s, input int e,
                              input logic [29:0] d, input int wen,
                              input int addr, input logic [11:0] wd,
                              input int done, input int err, input int cnt);
    vec_t r;
    r.v    = 1'(v);
    r.s    = 1'(s);
    r.e    = 1'(e);
    r.d    = d;
    r.wrr  = 1'b1;
    r.rdy  = 1'b1;
    r.wen  = 1'(wen);
    r.addr = 3'(addr);
    r.wd   = wd;
    r.done = 1'(done);
    r.err  = 1'(err);
    r.cnt  = 16'(cnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d, t=%0t): got %0h, expected %0h",
               name, cur, $time, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    valid_in         = v.v;
    startofpacket_in = v.s;
    endofpacket_in   = v.e;
    data_in_avalon   = v.d;
    wr_ready         = v.wrr;
    #1;
    chk("ready_out", 32'(ready_out), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk("wr_en",       32'(wr_en),       32'(v.wen));
    chk("wr_addr",     32'(wr_addr),     32'(v.addr));
    chk("wr_data",     32'(wr_data),     32'(v.wd));
    chk("frame_done",  32'(frame_done),  32'(v.done));
    chk("frame_error", 32'(frame_error), 32'(v.err));
    chk("frame_count", 32'(frame_count), 32'(v.cnt));
    n_vec++;
    cur++;
  endtask

  initial begin
    logic [3:0]  n;
    logic        bp_pat[4];
    logic [11:0] bp_exp[8];
    int          beat, wcount, ndone, cyc;
    logic        acc, fire, stall;
    logic [2:0]  sa;
    logic [11:0] sd;

    // ---------------- vector tables ----------------
    // good 8-pixel frame
    vecs_main.push_back(mk(1,1,0,30'h3FF00000,  1,0,12'hF00,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(1,2,3),     1,1,12'h123,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(4,5,6),     1,2,12'h456,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(7,8,9),     1,3,12'h789,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(10,11,12),  1,4,12'hABC,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(13,14,15),  1,5,12'hDEF,0,0,0));
    vecs_main.push_back(mk(1,0,0,px(0,15,0),    1,6,12'h0F0,0,0,0));
    vecs_main.push_back(mk(1,0,1,px(0,0,15),    1,7,12'h00F,1,0,1));
    vecs_main.push_back(mk(0,0,0,30'h0,         0,7,12'h00F,0,0,1));
    // short frame: EOP on beat 5
    for (int i = 0; i < 6; i++) begin
      n = 4'(i);
      vecs_main.push_back(mk(1, int'(i==0), int'(i==5), px(n,n,n),
                             1, i, {n,n,n}, 0, int'(i==5), 1));
    end
    vecs_main.push_back(mk(0,0,0,30'h0,         0,5,12'h555,0,0,1));
    // overflow: 10 beats, EOP on beat 9
    for (int i = 0; i < 8; i++) begin
      n = 4'(i);
      vecs_main.push_back(mk(1, int'(i==0), 0, px(n,0,0),
                             1, i, {n,8'h00}, 0, 0, 1));
    end
    vecs_main.push_back(mk(1,0,0,px(8,0,0),     0,7,12'h700,0,0,1));
    vecs_main.push_back(mk(1,0,1,px(9,0,0),     0,7,12'h700,0,1,1));
    vecs_main.push_back(mk(0,0,0,30'h0,         0,7,12'h700,0,0,1));
    // stray beats in IDLE, then a frame restarted by a second SOP
    vecs_main.push_back(mk(1,0,0,px(15,15,15),  0,7,12'h700,0,0,1));
    vecs_main.push_back(mk(1,0,1,px(15,15,15),  0,7,12'h700,0,0,1));
    vecs_main.push_back(mk(1,0,0,px(15,15,15),  0,7,12'h700,0,0,1));
    vecs_main.push_back(mk(1,1,0,px(0,10,0),    1,0,12'h0A0,0,0,1));
    vecs_main.push_back(mk(1,0,0,px(0,11,0),    1,1,12'h0B0,0,0,1));
    vecs_main.push_back(mk(1,0,0,px(0,12,0),    1,2,12'h0C0,0,0,1));
    vecs_main.push_back(mk(1,0,0,px(0,13,0),    1,3,12'h0D0,0,0,1));
    vecs_main.push_back(mk(1,1,0,px(1,1,1),     1,0,12'h111,0,1,1));
    for (int k = 1; k < 8; k++) begin
      n = 4'(k + 1);
      vecs_main.push_back(mk(1, 0, int'(k==7), px(n,n,n),
                             1, k, {n,n,n}, int'(k==7), 0, (k==7) ? 2 : 1));
    end
    vecs_main.push_back(mk(0,0,0,30'h0,         0,7,12'h888,0,0,2));
    // SOP+EOP on one beat: written as pixel 0, error, back to IDLE
    vecs_main.push_back(mk(1,1,1,px(3,3,3),     1,0,12'h333,0,1,2));
    vecs_main.push_back(mk(1,0,0,px(4,4,4),     0,0,12'h333,0,0,2));
    // after reset: fresh frame from address 0, ended short
    vecs_post.push_back(mk(1,1,0,px(5,5,5),     1,0,12'h555,0,0,0));
    vecs_post.push_back(mk(1,0,0,px(6,7,8),     1,1,12'h678,0,0,0));
    vecs_post.push_back(mk(1,0,1,px(9,10,11),   1,2,12'h9AB,0,1,0));
    vecs_post.push_back(mk(0,0,0,30'h0,         0,2,12'h9AB,0,0,0));

    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bp_exp = '{12'h101, 12'h202, 12'h303, 12'h404,
               12'h505, 12'h606, 12'h707, 12'h808};

    // ---------------- reset state ----------------
    rst              = 1'b0;
    valid_in         = 1'b0;
    startofpacket_in = 1'b0;
    endofpacket_in   = 1'b0;
    data_in_avalon   = '0;
    wr_ready         = 1'b1;
    #3;
    chk("rst_ready_out",   32'(ready_out),   32'd0);
    chk("rst_wr_en",       32'(wr_en),       32'd0);
    chk("rst_wr_addr",     32'(wr_addr),     32'd0);
    chk("rst_wr_data",     32'(wr_data),     32'd0);
    chk("rst_frame_done",  32'(frame_done),  32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs_main[i]) run_vec(vecs_main[i]);

    // ---------------- backpressure: wr_ready 1,0,0,1,... ----------------
    beat = 0; wcount = 0; ndone = 0; cyc = 0;
    while ((beat < 8 || wcount < 8) && cyc < 200) begin
      @(negedge clk);
      wr_ready = bp_pat[cyc % 4];
      if (beat < 8) begin
        n                = 4'(beat + 1);
        valid_in         = 1'b1;
        startofpacket_in = (beat == 0);
        endofpacket_in   = (beat == 7);
        data_in_avalon   = px(n, 4'h0, n);
      end else begin
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
      end
      #1;
      if (wr_en && !wr_ready) chk("bp_ready_stalled", 32'(ready_out), 32'd0);
      if (!wr_en)             chk("bp_ready_empty",   32'(ready_out), 32'd1);
      acc   = valid_in && ready_out;
      fire  = wr_en && wr_ready;
      stall = wr_en && !wr_ready;
      sa    = wr_addr;
      sd    = wr_data;
      if (fire) begin
        if (wcount < 8) begin
          chk("bp_wr_addr", 32'(wr_addr), 32'(wcount));
          chk("bp_wr_data", 32'(wr_data), 32'(bp_exp[wcount]));
        end else begin
          chk("bp_extra_write", 32'(wcount), 32'd7);
        end
        wcount++;
      end
      @(posedge clk);
      #1;
      if (acc) beat++;
      if (stall) begin
        chk("bp_hold_en",   32'(wr_en),   32'd1);
        chk("bp_hold_addr", 32'(wr_addr), 32'(sa));
        chk("bp_hold_data", 32'(wr_data), 32'(sd));
      end
      if (frame_done) ndone++;
      chk("bp_no_error", 32'(frame_error), 32'd0);
      n_vec++;
      cyc++;
    end
    if (cyc >= 200) chk("bp_timeout", 32'(cyc), 32'd0);
    chk("bp_writes",      32'(wcount),      32'd8);
    chk("bp_done_pulses", 32'(ndone),       32'd1);
    chk("bp_frame_count", 32'(frame_count), 32'd3);
    @(negedge clk);
    wr_ready = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_idle_wr_en", 32'(wr_en), 32'd0);

    // ---------------- reset mid-frame ----------------
    run_vec(mk(1,1,0,px(6,6,6), 1,0,12'h666,0,0,3));
    run_vec(mk(1,0,0,px(7,7,7), 1,1,12'h777,0,0,3));
    run_vec(mk(1,0,0,px(8,8,8), 1,2,12'h888,0,0,3));
    @(negedge clk);
    valid_in         = 1'b1;
    startofpacket_in = 1'b0;
    endofpacket_in   = 1'b0;
    data_in_avalon   = px(9,9,9);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en",       32'(wr_en),       32'd0);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    chk("mid_rst_ready_out",   32'(ready_out),   32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("in_rst_ready_out",   32'(ready_out),   32'd0);
      chk("in_rst_wr_en",       32'(wr_en),       32'd0);
      chk("in_rst_frame_done",  32'(frame_done),  32'd0);
      chk("in_rst_frame_error", 32'(frame_error), 32'd0);
      n_vec++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_frame_error", 32'(frame_error), 32'd0);

    foreach (vecs_post[i]) run_vec(vecs_post[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_st_to_frame_writer.md
Name: avalon_st_to_frame_writer

Overview:
- Avalon-ST sink; the receive-side counterpart of the camera pixel-to-Avalon source.
- Accepts 30-bit RGB (10 bits per channel) video packets and packs each pixel back to 12-bit RGB444.
- Writes pixels sequentially into a frame buffer write port.
- Validates packet framing (SOP/EOP versus WIDTH*HEIGHT) and reports frame completion and framing errors.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- data_in_avalon  in  30  pixel {R[9:0],G[9:0],B[9:0]}.
- startofpacket_in  in  1  SOP, first pixel of frame.
- endofpacket_in  in  1  EOP, last pixel of frame.
- valid_in  in  1  beat valid.
- ready_out  out  1  sink ready.
- wr_addr  out  ADDR_W  frame buffer write address.
- wr_data  out  12  packed pixel {R[3:0],G[3:0],B[3:0]}.
- wr_en  out  1  write request.
- wr_ready  in  1  frame buffer accepts the write this cycle.
- frame_done  out  1  one-cycle pulse: frame received with correct length.
- frame_error  out  1  one-cycle pulse: framing error.
- frame_count  out  16  count of good frames, wraps 0xFFFF->0.

Behaviour:
- Reset (rst low, async): state=IDLE, pixel counter=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_error=0, frame_count=0. ready_out is forced 0 while rst is low.
- Reset mid-frame discards the partial frame. No error pulse is issued.
- Beat accepted at a rising edge when valid_in && ready_out.
- ready_out = !wr_en || wr_ready (single output register; no skid).
- Packing: wr_data = {d[29:26], d[19:16], d[9:6]}, i.e. the top 4 bits of each channel.
- Write register: accepted pixel beat at edge k → wr_en=1, wr_addr=pixel index, wr_data valid after edge k.
- Write register hold: contents held stable until an edge where wr_en && wr_ready. wr_en then drops unless a new beat is accepted at that same edge.
- FSM IDLE: non-SOP beats are accepted and dropped (no write, no error). An SOP beat is written at address 0, counter=1, next state RECV.
- FSM RECV: each beat is written at address=counter, then counter increments.
- FSM RECV, SOP received: abort the current frame and pulse frame_error. This beat is written as pixel 0, counter=1, stay in RECV.
- FSM RECV, EOP received: if the beat is pixel WIDTH*HEIGHT-1, pulse frame_done, increment frame_count, go to IDLE. Otherwise (short frame) write the beat, pulse frame_error, go to IDLE.
- FSM RECV, counter reaches WIDTH*HEIGHT with no EOP: go to OVERFLOW.
- FSM OVERFLOW: beats are accepted and dropped, no writes.
- FSM OVERFLOW, EOP received: pulse frame_error, go to IDLE.
- FSM OVERFLOW, SOP received: pulse frame_error, handle as SOP in IDLE (pixel 0 written, RECV).
- SOP and EOP on the same beat: write pixel 0. Pulse frame_done if WIDTH*HEIGHT==1, else frame_error. Go to IDLE.
- Status pulses: frame_done and frame_error are registered. They assert for exactly one cycle, after the edge accepting the terminating beat, coincident with the final wr_en. The two are never high together.
- Address never exceeds WIDTH*HEIGHT-1.
- Backpressure: wr_ready low stalls the input via ready_out. No beat is lost or duplicated.

Test Plan:
- WIDTH=4, HEIGHT=2, rst released, wr_ready=1. Send 8 beats with SOP on 0, EOP on 7, data=30'h3FF_00000 style patterns → 8 writes at addr 0..7, wr_data=12'hF00 for pixels with R=10'h3FF and G=B=0. frame_done pulses once, frame_count=1, frame_error never set.
- Same frame with wr_ready toggled 1,0,0,1 repeatedly → ready_out follows the stalls, wr_addr/wr_data stay stable while stalled, exactly 8 writes in order, frame_done=1 once.
- EOP on beat 5 → writes at addr 0..5, frame_error pulse, no frame_done, frame_count unchanged. A following good frame restarts at addr 0.
- 10 beats with no EOP until beat 9 → writes at addr 0..7 only, beats 8..9 dropped, frame_error pulse on the EOP edge, state IDLE.
- 3 non-SOP beats in IDLE, then a frame with a second SOP at beat 4 → first 3 beats dropped without error. frame_error pulses on the second SOP, which is written at addr 0. The frame then completes normally with frame_done.
- Assert rst low in the middle of beat 3 of a frame → wr_en=0, frame_count=0, no pulses, ready_out=0 during reset. After release, the next SOP frame writes from addr 0.
